// File: rtl/l_output_port_ctrl_if.sv
// Flit/handshake bundle between the four input buffers, the arbiter grants and the
// L output port controller. master = upstream/downstream environment, slave = controller.
interface l_output_port_ctrl_if #(
   parameter int unsigned DATA_W = 32
);
   logic              rrp_l_priority_n_i;
   logic              rrp_l_priority_s_i;
   logic              rrp_l_priority_w_i;
   logic              rrp_l_priority_e_i;
   logic              n_flit_valid_i;
   logic              s_flit_valid_i;
   logic              w_flit_valid_i;
   logic              e_flit_valid_i;
   logic              n_flit_tail_i;
   logic              s_flit_tail_i;
   logic              w_flit_tail_i;
   logic              e_flit_tail_i;
   logic [DATA_W-1:0] n_flit_data_i;
   logic [DATA_W-1:0] s_flit_data_i;
   logic [DATA_W-1:0] w_flit_data_i;
   logic [DATA_W-1:0] e_flit_data_i;
   logic              l_credit_return_i;
   logic              n_pop_o;
   logic              s_pop_o;
   logic              w_pop_o;
   logic              e_pop_o;
   logic              l_flit_valid_o;
   logic [DATA_W-1:0] l_flit_data_o;

   modport master (
      output rrp_l_priority_n_i, rrp_l_priority_s_i, rrp_l_priority_w_i, rrp_l_priority_e_i,
      output n_flit_valid_i, s_flit_valid_i, w_flit_valid_i, e_flit_valid_i,
      output n_flit_tail_i, s_flit_tail_i, w_flit_tail_i, e_flit_tail_i,
      output n_flit_data_i, s_flit_data_i, w_flit_data_i, e_flit_data_i,
      output l_credit_return_i,
      input  n_pop_o, s_pop_o, w_pop_o, e_pop_o,
      input  l_flit_valid_o, l_flit_data_o
   );

   modport slave (
      input  rrp_l_priority_n_i, rrp_l_priority_s_i, rrp_l_priority_w_i, rrp_l_priority_e_i,
      input  n_flit_valid_i, s_flit_valid_i, w_flit_valid_i, e_flit_valid_i,
      input  n_flit_tail_i, s_flit_tail_i, w_flit_tail_i, e_flit_tail_i,
      input  n_flit_data_i, s_flit_data_i, w_flit_data_i, e_flit_data_i,
      input  l_credit_return_i,
      output n_pop_o, s_pop_o, w_pop_o, e_pop_o,
      output l_flit_valid_o, l_flit_data_o
   );
endinterface

// File: rtl/l_output_port_ctrl.sv
// L output-port controller: locks the L output to the granted input for a whole packet and
// forwards flits under credit flow control. Define L_OPC_WATCHDOG_EN for the stall watchdog.
module l_output_port_ctrl #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned CREDIT_MAX  = 4,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   l_output_port_ctrl_if.slave  bus,
   output logic [2:0]           l_cs_select_o,
   output logic                 rr_register_change_order_o,
   output logic                 credit_err_o,
   output logic                 timeout_err_o
);
   localparam int unsigned       CreditW    = $clog2(CREDIT_MAX + 1);
   localparam logic [CreditW-1:0] CreditFull = CreditW'(CREDIT_MAX);
   localparam logic [2:0]         SelIdle    = 3'd7;

   typedef enum logic {StIdle, StLocked} state_e;

   state_e              state_q, state_d;
   logic [2:0]          sel_q, sel_d;
   logic                co_q, co_d;
   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [CreditW-1:0]  credit_q, credit_d;
   logic                credit_err_q, credit_err_d;

   logic [3:0]          grant, in_valid, in_tail, pop;
   logic [DATA_W-1:0]   in_data [4];
   logic [1:0]          grant_idx;
   logic                sel_valid, sel_tail, xfer;
   logic [DATA_W-1:0]   sel_data;

   assign grant    = {bus.rrp_l_priority_e_i, bus.rrp_l_priority_w_i,
                      bus.rrp_l_priority_s_i, bus.rrp_l_priority_n_i};
   assign in_valid = {bus.e_flit_valid_i, bus.w_flit_valid_i,
                      bus.s_flit_valid_i, bus.n_flit_valid_i};
   assign in_tail  = {bus.e_flit_tail_i, bus.w_flit_tail_i,
                      bus.s_flit_tail_i, bus.n_flit_tail_i};
   assign in_data[0] = bus.n_flit_data_i;
   assign in_data[1] = bus.s_flit_data_i;
   assign in_data[2] = bus.w_flit_data_i;
   assign in_data[3] = bus.e_flit_data_i;

   // Lowest index wins on a multi-hot grant (N > S > W > E).
   always_comb begin
      grant_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (grant[i]) grant_idx = 2'(i);
      end
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_tail  = 1'b0;
      sel_data  = '0;
      if (state_q == StLocked) begin
         sel_valid = in_valid[sel_q[1:0]];
         sel_tail  = in_tail[sel_q[1:0]];
         sel_data  = in_data[sel_q[1:0]];
      end
   end

   assign xfer = sel_valid && (credit_q != '0);
   assign pop  = xfer ? (4'b0001 << sel_q[1:0]) : 4'b0000;

`ifdef L_OPC_WATCHDOG_EN
   localparam int unsigned   WdW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT_CYC - 1);

   logic [WdW-1:0] wd_q, wd_d;
   logic           timeout_err_q, timeout_err_d;
`endif

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      co_d         = 1'b0;
      valid_d      = xfer;
      data_d       = xfer ? sel_data : data_q;
      credit_d     = credit_q;
      credit_err_d = credit_err_q;

      case (state_q)
         StIdle: begin
            // The pulse cycle is a bubble so the arbiter's rotated order is in place.
            if ((grant != 4'b0000) && !co_q) begin
               state_d = StLocked;
               sel_d   = {1'b0, grant_idx};
            end
         end
         StLocked: begin
            if (xfer && sel_tail) begin
               state_d = StIdle;
               sel_d   = SelIdle;
               co_d    = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            sel_d   = SelIdle;
         end
      endcase

      if (xfer && !bus.l_credit_return_i) begin
         credit_d = credit_q - 1'b1;
      end else if (!xfer && bus.l_credit_return_i) begin
         if (credit_q == CreditFull) credit_err_d = 1'b1;
         else                        credit_d     = credit_q + 1'b1;
      end

`ifdef L_OPC_WATCHDOG_EN
      wd_d          = '0;
      timeout_err_d = timeout_err_q;
      if ((state_q == StLocked) && !xfer) begin
         if (wd_q == WdLimit) begin
            state_d       = StIdle;
            sel_d         = SelIdle;
            co_d          = 1'b1;
            timeout_err_d = 1'b1;
         end else begin
            wd_d = wd_q + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         sel_q         <= SelIdle;
         co_q          <= 1'b0;
         valid_q       <= 1'b0;
         data_q        <= '0;
         credit_q      <= CreditFull;
         credit_err_q  <= 1'b0;
`ifdef L_OPC_WATCHDOG_EN
         wd_q          <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         co_q          <= co_d;
         valid_q       <= valid_d;
         data_q        <= data_d;
         credit_q      <= credit_d;
         credit_err_q  <= credit_err_d;
`ifdef L_OPC_WATCHDOG_EN
         wd_q          <= wd_d;
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

   assign bus.n_pop_o                = pop[0];
   assign bus.s_pop_o                = pop[1];
   assign bus.w_pop_o                = pop[2];
   assign bus.e_pop_o                = pop[3];
   assign bus.l_flit_valid_o         = valid_q;
   assign bus.l_flit_data_o          = data_q;
   assign l_cs_select_o              = sel_q;
   assign rr_register_change_order_o = co_q;
   assign credit_err_o               = credit_err_q;
`ifdef L_OPC_WATCHDOG_EN
   assign timeout_err_o              = timeout_err_q;
`else
   assign timeout_err_o              = 1'b0;
`endif
endmodule
